piso_serializer: RTL
====================

# piso_serializer

Parallel-in serial-out stage directly downstream of the 16-bit PIPO register. It captures the PIPO's parallel output word on a load handshake and shifts it out one bit per clock on a single serial line with a valid qualifier and a completion pulse. It bridges the parallel datapath to serial transmit logic such as a UART or SPI front end.

## Interface
Parameters:
- WIDTH, 16: word width in bits, legal range 2–32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is shifted first; 0 = bit 0 is shifted first.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- clr  input  1  reset, asynchronous and active-high.
- data_in  input  WIDTH  parallel word, driven by the PIPO q output.
- load  input  1  request to capture data_in.
- ready  output  1  block can accept a load this cycle.
- sout  output  1  serial data bit.
- sout_valid  output  1  sout carries a valid bit this cycle.
- busy  output  1  a word is in flight.
- done  output  1  one-cycle pulse after the final bit.

## Operation
- Registered FSM states: IDLE, SHIFT, PAR, DONE. PAR exists only with the macro enabled.
- Reset state is IDLE. Reset values: sout=0, sout_valid=0, busy=0, done=0, shift register=0, bit counter=0. Because the state is IDLE, ready=1 once clr is released.
- ready = (state==IDLE) || (state==DONE). This is combinational from the state only.
- A load is accepted when load && ready at a rising edge. The block captures data_in into the shift register, clears the bit counter and enters SHIFT.
- SHIFT:
  - sout = MSB_FIRST ? sr[WIDTH-1] : sr[0].
  - sout_valid=1 and busy=1.
  - Each cycle the register shifts by one: left for MSB_FIRST, right otherwise, zero-filled.
  - The bit counter increments each cycle.
  - After WIDTH bits have been sent, the FSM moves to PAR if enabled, otherwise to DONE.
- PAR: sout = even parity (XOR) of the captured word, sout_valid=1, busy=1. Next state is DONE.
- DONE: done=1, busy=0, sout_valid=0, sout=0.
  - With load asserted, the FSM goes straight to SHIFT and captures the new word.
  - Otherwise it returns to IDLE.
- load while in SHIFT or PAR is ignored; no queuing.
- data_in is sampled only at the accepting edge. Changes afterwards have no effect on the word in flight.
- clr asserted mid-word aborts the word immediately. All outputs take their reset values and no done pulse is issued.
- Bit counter width is $clog2(WIDTH+1). It never wraps within a word.

## Timing
- All outputs are registered except ready.
- Load accepted at edge N puts the first bit on sout during cycle N+1.
- The last data bit appears at cycle N+WIDTH.
- The parity bit, when enabled, appears at cycle N+WIDTH+1.
- done pulses in the following cycle: N+WIDTH+1 without parity, N+WIDTH+2 with parity.
- Back-to-back words via load in DONE give a throughput of one word per WIDTH+1 cycles, or WIDTH+2 with parity.
- load and clr in the same cycle: clr wins.

## Configuration
- PISO_PARITY_EN defined: the PAR state exists and one even-parity bit is appended after the data bits with sout_valid=1.
- PISO_PARITY_EN undefined: the PAR state, parity logic and parity register are removed. SHIFT goes directly to DONE.

## Structure
- Shared package piso_pkg holds the state encoding constants (IDLE, SHIFT, PAR, DONE, 2-bit) and the default WIDTH constant. The PIPO stage reuses that default.
- One natural sub-module, piso_bit_counter:
  - synchronous clear on load acceptance, increment enable in SHIFT;
  - terminal-count output at WIDTH-1;
  - async clr.
- Top-level FSM, shift register and parity register live in piso_serializer.

## Test plan
- Reset: assert clr for 25 ns while load=1 → sout=0, sout_valid=0, busy=0, done=0 throughout. ready=1 after release. No capture occurs.
- MSB-first word: load 16'h0001 → sout is 15 zeros then 1, sout_valid high for exactly 16 cycles, done one cycle later. With parity, a 1 is sent before done.
- LSB-first, MSB_FIRST=0: load 16'h0007 → sout is 1,1,1 then 13 zeros. The parity bit is 1 when PISO_PARITY_EN is defined.
- Ignored load: load 16'hA5A5, then at bit 4 present 16'hFFFF with load=1 → the serial stream still equals 16'hA5A5 and the second word is never sent.
- Back-to-back: hold load=1 with 16'h8001 then 16'h0003 → the second word's first bit follows done with no IDLE cycle, and done pulses once per word.
- Abort: clr asserted at bit 8 of 16'hFFFF → outputs reset asynchronously and no done pulse. A fresh load of 16'h0001 after release serializes correctly.

Source files
------------

// File: rtl/piso_pkg.sv
// piso_pkg: shared FSM state encoding and default word width for the PIPO/PISO datapath
package piso_pkg;
  localparam int PISO_WIDTH = 16;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/piso_bit_counter.sv
// piso_bit_counter: counts bits sent in a word, flags the final data bit
// Ports: clk, clr (async reset), clear (sync clear on load accept),
//        en (count in SHIFT), tc (count == WIDTH-1)
module piso_bit_counter #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic clear,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  end
  assign tc = cnt == CW'(WIDTH - 1);
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: captures a parallel word on load and shifts it out one bit per clock
// Ports: clk, clr (async active-high reset), data_in, load -> ready (comb),
//        sout, sout_valid, busy, done (registered)
// Build option: define PISO_PARITY_EN to append one even-parity bit after the data bits.
module piso_serializer import piso_pkg::*; #(
  parameter int WIDTH     = PISO_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);
  state_t state, nxt;
  logic [WIDTH-1:0] sr, nxt_sr;
  logic accept, tc, nxt_sout, nxt_valid;
  assign ready  = (state == IDLE) || (state == DONE);
  assign accept = load && ready;
  piso_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .clr   (clr),
    .clear (accept),
    .en    (state == SHIFT),
    .tc    (tc)
  );
`ifdef PISO_PARITY_EN
  localparam state_t LAST = PAR;
  logic par;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) par <= 1'b0;
    else if (accept) par <= ^data_in;
  end
`else
  localparam state_t LAST = DONE;
`endif
  // Outputs are registered, so they are decoded from the next state and next shift value.
  always_comb begin
    nxt    = state;
    nxt_sr = sr;
    if (accept) begin
      nxt    = SHIFT;
      nxt_sr = data_in;
    end else if (state == SHIFT) begin
      nxt_sr = MSB_FIRST ? sr << 1 : sr >> 1;
      nxt    = tc ? LAST : SHIFT;
    end else if (state == DONE) nxt = IDLE;
`ifdef PISO_PARITY_EN
    else if (state == PAR) nxt = DONE;
    nxt_valid = (nxt == SHIFT) || (nxt == PAR);
    nxt_sout  = (nxt == SHIFT) ? (MSB_FIRST ? nxt_sr[WIDTH-1] : nxt_sr[0]) : (nxt == PAR) && par;
`else
    nxt_valid = nxt == SHIFT;
    nxt_sout  = (nxt == SHIFT) && (MSB_FIRST ? nxt_sr[WIDTH-1] : nxt_sr[0]);
`endif
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= IDLE;
      sr         <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= nxt;
      sr         <= nxt_sr;
      sout       <= nxt_sout;
      sout_valid <= nxt_valid;
      busy       <= nxt_valid;
      done       <= nxt == DONE;
    end
  end
endmodule
